voice_allocator: RTL and testbench

// Sits between midi_ctrl and synth2 and schedules the synth's NUM_VOICES voice slots among incoming MIDI notes.

---
 rtl/voice_allocator_if.sv | 51 +++++
 rtl/voice_allocator.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// ----------------------------------------------------------------------------
// voice_allocator_if
// Groups the MIDI event inputs and the voice-update outputs of voice_allocator.
//   master : drives the MIDI event (midi_ctrl side / testbench)
//   slave  : the allocator; receives events and drives voice updates
// Signals
//   note_pressed/note_released  1-cycle event pulses
//   note, velocity, channel     event payload, valid with the pulse
//   upd_valid                   1-cycle voice update strobe
//   upd_voice/gate/note/vel     registered update payload, held until next update
//   upd_steal                   slot was taken from another note
//   voices_active               bit i = slot i sounding
//   busy, drop                  allocator busy / event discarded pulse
//   dbg_state                   current FSM state (IDLE=0, SCAN=1, ISSUE=2)
// Handshake: there is no back-pressure. An event is offered for exactly one
// cycle; it is either taken into the pending slot or reported via drop one
// cycle later. upd_valid is a single-cycle strobe with no ready.
// ----------------------------------------------------------------------------
interface voice_allocator_if #(
    parameter int NUM_VOICES = 8,
    parameter int VW         = $clog2(NUM_VOICES)
);
    logic                  note_pressed;
    logic                  note_released;
    logic [6:0]            note;
    logic [6:0]            velocity;
    logic [3:0]            channel;

    logic                  upd_valid;
    logic [VW-1:0]         upd_voice;
    logic                  upd_gate;
    logic [6:0]            upd_note;
    logic [6:0]            upd_vel;
    logic                  upd_steal;
    logic [NUM_VOICES-1:0] voices_active;
    logic                  busy;
    logic                  drop;
    logic [1:0]            dbg_state;

    modport master (
        output note_pressed, note_released, note, velocity, channel,
        input  upd_valid, upd_voice, upd_gate, upd_note, upd_vel, upd_steal,
        input  voices_active, busy, drop, dbg_state
    );

    modport slave (
        input  note_pressed, note_released, note, velocity, channel,
        output upd_valid, upd_voice, upd_gate, upd_note, upd_vel, upd_steal,
        output voices_active, busy, drop, dbg_state
    );
endinterface

// File: rtl/voice_allocator.sv
// ----------------------------------------------------------------------------
// voice_allocator
// Maps incoming MIDI note-on/note-off events onto NUM_VOICES synth voice
// slots. A note-on retriggers the slot already holding the note, else takes
// the lowest free slot, else steals the oldest sounding slot. A note-off
// closes the slot holding the note. One update strobe per accepted event.
// Ports
//   clk     system clock
//   nreset  synchronous active-low reset
//   bus     voice_allocator_if.slave (events in, voice updates out)
// Flow: event -> 1-deep pending register -> IDLE -> SCAN (one slot per
// cycle) -> ISSUE (table write) -> IDLE.
// ----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8,
    parameter int OMNI       = 1,
    parameter int CHANNEL    = 0
) (
    input  logic              clk,
    input  logic              nreset,
    voice_allocator_if.slave  bus
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t r_state;

    // Pending event (1-deep)
    logic                  r_pend_full;
    logic                  r_pend_press;
    logic [6:0]            r_pend_note;
    logic [6:0]            r_pend_vel;

    // Working event under scan
    logic                  r_work_press;
    logic [6:0]            r_work_note;
    logic [6:0]            r_work_vel;

    // Scan trackers
    logic [VW-1:0]         r_idx;
    logic                  r_match_found;
    logic [VW-1:0]         r_match_idx;
    logic                  r_free_found;
    logic [VW-1:0]         r_free_idx;
    logic                  r_old_found;
    logic [VW-1:0]         r_old_idx;
    logic [AGE_W-1:0]      r_old_age;

    // Decision carried from the last SCAN cycle into ISSUE
    logic                  r_apply;
    logic [VW-1:0]         r_sel_voice;
    logic                  r_sel_press;

    // Slot table
    logic [NUM_VOICES-1:0] r_active;
    logic [6:0]            r_note [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];

    // Registered outputs
    logic                  r_upd_valid;
    logic [VW-1:0]         r_upd_voice;
    logic                  r_upd_gate;
    logic [6:0]            r_upd_note;
    logic [6:0]            r_upd_vel;
    logic                  r_upd_steal;
    logic                  r_busy;
    logic                  r_drop;

    // ------------------------------------------------------------------
    // Event filter and pending-slot admission
    // ------------------------------------------------------------------
    logic w_chan_ok;
    logic w_press_in;
    logic w_rel_in;
    logic w_ev;
    logic w_take;
    logic w_pend_room;
    logic w_capture;
    logic w_drop;
    logic w_busy_nxt;

    assign w_chan_ok  = (OMNI != 0) || (bus.channel == 4'(CHANNEL));
    // A zero-velocity note-on is a note-off in MIDI.
    assign w_press_in = w_chan_ok && bus.note_pressed && (bus.velocity != 7'd0);
    assign w_rel_in   = w_chan_ok && (bus.note_released ||
                                      (bus.note_pressed && (bus.velocity == 7'd0)));
    assign w_ev       = w_press_in || w_rel_in;
    // The pending slot frees up in the same cycle IDLE hands it to the
    // working register, so a new event can land there back-to-back.
    assign w_take      = (r_state == ST_IDLE) && r_pend_full;
    assign w_pend_room = !r_pend_full || w_take;
    assign w_capture   = w_ev && w_pend_room;
    // Simultaneous press+release keeps the release and discards the press.
    assign w_drop      = (w_ev && !w_pend_room) || (w_press_in && w_rel_in);
    // Busy covers the cycle where a captured event waits in IDLE.
    assign w_busy_nxt  = (r_state == ST_SCAN) || r_pend_full || w_capture;

    // ------------------------------------------------------------------
    // Scan step for slot r_idx, merged with the trackers so far
    // ------------------------------------------------------------------
    logic             w_cur_active;
    logic [6:0]       w_cur_note;
    logic [AGE_W-1:0] w_cur_age;
    logic             w_match_found;
    logic [VW-1:0]    w_match_idx;
    logic             w_free_found;
    logic [VW-1:0]    w_free_idx;
    logic             w_old_take;
    logic             w_old_found;
    logic [VW-1:0]    w_old_idx;
    logic [AGE_W-1:0] w_old_age;
    logic             w_last;

    assign w_cur_active  = r_active[r_idx];
    assign w_cur_note    = r_note[r_idx];
    assign w_cur_age     = r_age[r_idx];

    assign w_match_found = r_match_found || (w_cur_active && (w_cur_note == r_work_note));
    assign w_match_idx   = r_match_found ? r_match_idx : r_idx;
    assign w_free_found  = r_free_found || !w_cur_active;
    assign w_free_idx    = r_free_found ? r_free_idx : r_idx;
    // Strict '>' keeps the lowest index on equal ages.
    assign w_old_take    = w_cur_active && (!r_old_found || (w_cur_age > r_old_age));
    assign w_old_found   = r_old_found || w_cur_active;
    assign w_old_idx     = w_old_take ? r_idx : r_old_idx;
    assign w_old_age     = w_old_take ? w_cur_age : r_old_age;
    assign w_last        = (r_idx == VW'(NUM_VOICES - 1));

    // Final slot choice, valid on the last SCAN cycle
    logic          w_dec_apply;
    logic [VW-1:0] w_dec_voice;
    logic          w_dec_steal;

    always_comb begin
        w_dec_apply = 1'b0;
        w_dec_voice = w_match_idx;
        w_dec_steal = 1'b0;
        if (r_work_press) begin
            w_dec_apply = 1'b1;
            if (w_match_found) begin
                w_dec_voice = w_match_idx;
            end else if (w_free_found) begin
                w_dec_voice = w_free_idx;
            end else begin
                w_dec_voice = w_old_idx;
                w_dec_steal = 1'b1;
            end
        end else if (w_match_found) begin
            w_dec_apply = 1'b1;
            w_dec_voice = w_match_idx;
        end
    end

    // ------------------------------------------------------------------
    // FSM, pending register, table and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state       <= ST_IDLE;
            r_pend_full   <= 1'b0;
            r_pend_press  <= 1'b0;
            r_pend_note   <= '0;
            r_pend_vel    <= '0;
            r_work_press  <= 1'b0;
            r_work_note   <= '0;
            r_work_vel    <= '0;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
            r_apply       <= 1'b0;
            r_sel_voice   <= '0;
            r_sel_press   <= 1'b0;
            r_active      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
                r_age[i]  <= '0;
            end
            r_upd_valid   <= 1'b0;
            r_upd_voice   <= '0;
            r_upd_gate    <= 1'b0;
            r_upd_note    <= '0;
            r_upd_vel     <= '0;
            r_upd_steal   <= 1'b0;
            r_busy        <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_upd_valid <= 1'b0;
            r_drop      <= w_drop;
            r_busy      <= w_busy_nxt;

            if (w_capture) begin
                r_pend_full  <= 1'b1;
                r_pend_press <= w_press_in && !w_rel_in;
                r_pend_note  <= bus.note;
                r_pend_vel   <= bus.velocity;
            end else if (w_take) begin
                r_pend_full  <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_full) begin
                        r_work_press  <= r_pend_press;
                        r_work_note   <= r_pend_note;
                        r_work_vel    <= r_pend_vel;
                        r_idx         <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_old_found   <= 1'b0;
                        r_old_age     <= '0;
                        r_state       <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    r_match_found <= w_match_found;
                    r_match_idx   <= w_match_idx;
                    r_free_found  <= w_free_found;
                    r_free_idx    <= w_free_idx;
                    r_old_found   <= w_old_found;
                    r_old_idx     <= w_old_idx;
                    r_old_age     <= w_old_age;
                    r_idx         <= r_idx + 1'b1;
                    if (w_last) begin
                        // Outputs are launched here so the strobe sits in the
                        // ISSUE cycle; the table itself is written in ISSUE.
                        r_apply     <= w_dec_apply;
                        r_sel_voice <= w_dec_voice;
                        r_sel_press <= r_work_press;
                        r_upd_valid <= w_dec_apply;
                        if (w_dec_apply) begin
                            r_upd_voice <= w_dec_voice;
                            r_upd_gate  <= r_work_press;
                            r_upd_note  <= r_work_note;
                            r_upd_vel   <= r_work_press ? r_work_vel : 7'd0;
                            r_upd_steal <= w_dec_steal;
                        end
                        r_state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (r_apply) begin
                        if (r_sel_press) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (VW'(i) == r_sel_voice) begin
                                    r_active[i] <= 1'b1;
                                    r_note[i]   <= r_work_note;
                                    r_age[i]    <= '0;
                                end else if (r_active[i] && (r_age[i] != AGE_MAX)) begin
                                    r_age[i]    <= r_age[i] + 1'b1;
                                end
                            end
                        end else begin
                            r_active[r_sel_voice] <= 1'b0;
                        end
                    end
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.upd_valid     = r_upd_valid;
    assign bus.upd_voice     = r_upd_voice;
    assign bus.upd_gate      = r_upd_gate;
    assign bus.upd_note      = r_upd_note;
    assign bus.upd_vel       = r_upd_vel;
    assign bus.upd_steal     = r_upd_steal;
    assign bus.voices_active = r_active;
    assign bus.busy          = r_busy;
    assign bus.drop          = r_drop;
    assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_voice_allocator.sv
// ----------------------------------------------------------------------------
// tb_voice_allocator
// Directed bench for voice_allocator. Two instances share the event inputs:
// dut (OMNI=1) and dut_ch (OMNI=0, CHANNEL=2). Observed updates are packed
// as {steal, gate, vel, note, voice} and compared against hand-built
// expected words.
// ----------------------------------------------------------------------------
module tb_voice_allocator;
    localparam int NV = 8;
    localparam int W  = 19;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nreset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    voice_allocator_if #(.NUM_VOICES(NV)) bus ();
    voice_allocator_if #(.NUM_VOICES(NV)) bus_ch ();

    assign bus_ch.note_pressed  = bus.note_pressed;
    assign bus_ch.note_released = bus.note_released;
    assign bus_ch.note          = bus.note;
    assign bus_ch.velocity      = bus.velocity;
    assign bus_ch.channel       = bus.channel;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .OMNI(1), .CHANNEL(0)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(8), .OMNI(0), .CHANNEL(2)) dut_ch (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus_ch.slave)
    );

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];
    int           drop_cyc_q[$];
    int           ch_upd_n  = 0;
    int           ch_drop_n = 0;
    int           ev_cyc    = 0;

    always @(negedge clk) begin
        if (bus.upd_valid === 1'b1) begin
            obs_q.push_back({bus.upd_steal, bus.upd_gate, bus.upd_vel, bus.upd_note, bus.upd_voice});
            obs_cyc_q.push_back(cyc);
        end
        if (bus.drop === 1'b1) drop_cyc_q.push_back(cyc);
        if (bus_ch.upd_valid === 1'b1) ch_upd_n++;
        if (bus_ch.drop === 1'b1) ch_drop_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_upd(input int voice, input int gate, input int note, input int vel, input int steal);
        logic [2:0] v3;
        logic [6:0] n7;
        logic [6:0] vl7;
        v3  = 3'(voice);
        n7  = 7'(note);
        vl7 = 7'(vel);
        exp_q.push_back({1'(steal), 1'(gate), vl7, n7, v3});
    endtask

    task automatic check_updates(input string tag);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_upd"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
        obs_cyc_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.note_pressed  = 1'b0;
        bus.note_released = 1'b0;
        bus.note          = 7'd0;
        bus.velocity      = 7'd0;
        bus.channel       = 4'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nreset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        obs_q.delete();
        exp_q.delete();
        obs_cyc_q.delete();
        drop_cyc_q.delete();
        ch_upd_n  = 0;
        ch_drop_n = 0;
    endtask

    // One-cycle event; returns 1 time unit after the edge that samples it.
    task automatic drive_ev(input logic p, input logic r, input int n, input int v, input int ch);
        @(posedge clk); #1;
        bus.note_pressed  = p;
        bus.note_released = r;
        bus.note          = 7'(n);
        bus.velocity      = 7'(v);
        bus.channel       = 4'(ch);
        ev_cyc            = cyc;
        @(posedge clk); #1;
        bus.note_pressed  = 1'b0;
        bus.note_released = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nreset = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check("rst_upd_valid", 32'(bus.upd_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_drop", 32'(bus.drop), 0);
        check("rst_voices_active", 32'(bus.voices_active), 0);
        check("rst_upd_note", 32'(bus.upd_note), 0);
        check("rst_state", 32'(bus.dbg_state), 0);
        do_reset();

        // First press: latency and busy window
        drive_ev(1'b1, 1'b0, 60, 100, 0);
        @(negedge clk);
        check("t1_busy_c1", 32'(bus.busy), 1);
        repeat (9) @(negedge clk);
        check("t1_valid_c10", 32'(bus.upd_valid), 1);
        check("t1_busy_c10", 32'(bus.busy), 1);
        @(negedge clk);
        check("t1_valid_c11", 32'(bus.upd_valid), 0);
        check("t1_busy_c11", 32'(bus.busy), 0);
        check("t1_active", 32'(bus.voices_active), 32'h01);
        check("t1_latency", (obs_cyc_q.size() > 0) ? 32'(obs_cyc_q[0] - ev_cyc) : 32'hffff_ffff, 10);
        expect_upd(0, 1, 60, 100, 0);
        check_updates("t1");

        // Fill all slots, then steal the oldest twice, then retrigger
        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive_ev(1'b1, 1'b0, 60 + i, 100, 0);
            idle(12);
            expect_upd(i, 1, 60 + i, 100, 0);
        end
        check("t2_full", 32'(bus.voices_active), 32'hff);
        drive_ev(1'b1, 1'b0, 72, 100, 0);
        idle(12);
        expect_upd(0, 1, 72, 100, 1);
        drive_ev(1'b1, 1'b0, 73, 100, 0);
        idle(12);
        expect_upd(1, 1, 73, 100, 1);
        drive_ev(1'b1, 1'b0, 65, 50, 0);
        idle(12);
        expect_upd(5, 1, 65, 50, 0);
        check("t2_active", 32'(bus.voices_active), 32'hff);
        check_updates("t2");

        // Retrigger same note
        do_reset();
        drive_ev(1'b1, 1'b0, 60, 100, 0);
        idle(12);
        drive_ev(1'b1, 1'b0, 60, 50, 0);
        idle(12);
        expect_upd(0, 1, 60, 100, 0);
        expect_upd(0, 1, 60, 50, 0);
        check("t3_active", 32'(bus.voices_active), 32'h01);
        check_updates("t3");

        // Velocity-0 release, unmatched release, reuse of freed slot
        drive_ev(1'b1, 1'b0, 64, 90, 0);
        idle(12);
        expect_upd(1, 1, 64, 90, 0);
        drive_ev(1'b1, 1'b0, 64, 0, 0);
        idle(12);
        expect_upd(1, 0, 64, 0, 0);
        check("t4_after_off", 32'(bus.voices_active), 32'h01);
        drive_ev(1'b0, 1'b1, 99, 0, 0);
        idle(12);
        check("t4_after_rel99", 32'(bus.voices_active), 32'h01);
        drive_ev(1'b1, 1'b0, 70, 30, 0);
        idle(12);
        expect_upd(1, 1, 70, 30, 0);
        check("t4_active", 32'(bus.voices_active), 32'h03);
        check_updates("t4");

        // Three presses on consecutive cycles
        do_reset();
        @(posedge clk); #1;
        bus.note_pressed = 1'b1;
        bus.velocity     = 7'd100;
        bus.note         = 7'd40;
        ev_cyc           = cyc;
        @(posedge clk); #1;
        bus.note         = 7'd41;
        @(posedge clk); #1;
        bus.note         = 7'd42;
        @(posedge clk); #1;
        bus.note_pressed = 1'b0;
        idle(30);
        expect_upd(0, 1, 40, 100, 0);
        expect_upd(1, 1, 41, 100, 0);
        check("t5_drop_n", drop_cyc_q.size(), 1);
        check("t5_drop_cyc", (drop_cyc_q.size() > 0) ? 32'(drop_cyc_q[0] - ev_cyc) : 32'hffff_ffff, 3);
        check_updates("t5");

        // Press and release in the same cycle: release wins
        do_reset();
        drive_ev(1'b1, 1'b0, 50, 80, 0);
        idle(12);
        expect_upd(0, 1, 50, 80, 0);
        drive_ev(1'b1, 1'b1, 50, 80, 0);
        idle(14);
        expect_upd(0, 0, 50, 0, 0);
        check("t6_drop_n", drop_cyc_q.size(), 1);
        check("t6_drop_cyc", (drop_cyc_q.size() > 0) ? 32'(drop_cyc_q[0] - ev_cyc) : 32'hffff_ffff, 1);
        check("t6_active", 32'(bus.voices_active), 0);
        check_updates("t6");

        // Channel filter on dut_ch (CHANNEL=2)
        do_reset();
        drive_ev(1'b1, 1'b0, 33, 100, 5);
        idle(13);
        expect_upd(0, 1, 33, 100, 0);
        check("t7_ch5_upd", ch_upd_n, 0);
        check("t7_ch5_drop", ch_drop_n, 0);
        drive_ev(1'b1, 1'b0, 34, 100, 2);
        idle(13);
        expect_upd(1, 1, 34, 100, 0);
        check("t7_ch2_upd", ch_upd_n, 1);
        check("t7_ch_active", 32'(bus_ch.voices_active), 32'h01);
        check_updates("t7");

        // Reset in the middle of SCAN
        do_reset();
        drive_ev(1'b1, 1'b0, 20, 100, 0);
        idle(12);
        expect_upd(0, 1, 20, 100, 0);
        check_updates("t8a");
        check("t8_active_before", 32'(bus.voices_active), 32'h01);
        drive_ev(1'b1, 1'b0, 30, 100, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t8_in_scan", 32'(bus.dbg_state), 1);
        nreset = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        @(negedge clk);
        check("t8_busy", 32'(bus.busy), 0);
        check("t8_active", 32'(bus.voices_active), 0);
        check("t8_upd_valid", 32'(bus.upd_valid), 0);
        check("t8_upd_note", 32'(bus.upd_note), 0);
        idle(15);
        check_updates("t8b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
